// File: rtl/ysyx_22040750_mdu.sv
// Iterative radix-2 RV64M multiply/divide unit for the EX stage.
// One partial product or quotient bit per cycle; result held in DONE until accepted downstream.
module ysyx_22040750_mdu #(
  parameter int XLEN = 64
) (
  input  logic            I_sys_clk,
  input  logic            I_rst_n,
  input  logic            I_start,
  input  logic [3:0]      I_op,
  input  logic [1:0]      I_sign,
  input  logic            I_word,
  input  logic [XLEN-1:0] I_op1,
  input  logic [XLEN-1:0] I_op2,
  input  logic            I_out_ready,
  input  logic            I_flush,
  output logic            O_busy,
  output logic            O_valid,
  output logic [XLEN-1:0] O_result
);
  localparam int W = XLEN / 2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  typedef enum logic [1:0] {K_MUL, K_MULH, K_DIV, K_REM} kind_e;

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d, kind_sel;
  logic [6:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]     quot_q, quot_d, op1_q, op1_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                word_q, word_d, neg_q, neg_d, divz_q, divz_d, valid_q, valid_d;

  logic [XLEN-1:0] op1_ext, op2_ext, mag1, mag2, fix_raw, fix_res;
  logic            neg1, neg2, op_onehot, start_ok, is_div;
  logic [XLEN:0]   div_t, div_sub;
  logic            div_ge;
  logic [XLEN-1:0] rem_new;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;
  logic [6:0]      cnt_last;

  // Word ops narrow to the low half before sign handling.
  assign op1_ext = I_word ? {{W{I_sign[1] & I_op1[W-1]}}, I_op1[W-1:0]} : I_op1;
  assign op2_ext = I_word ? {{W{I_sign[0] & I_op2[W-1]}}, I_op2[W-1:0]} : I_op2;
  assign neg1    = I_sign[1] & op1_ext[XLEN-1];
  assign neg2    = I_sign[0] & op2_ext[XLEN-1];
  assign mag1    = neg1 ? -op1_ext : op1_ext;
  assign mag2    = neg2 ? -op2_ext : op2_ext;

  assign op_onehot = (I_op != 4'd0) && ((I_op & (I_op - 4'd1)) == 4'd0);
  assign start_ok  = I_start && op_onehot;
  assign is_div    = I_op[3] | I_op[2];
  assign kind_sel  = I_op[3] ? K_REM : I_op[2] ? K_DIV : (I_op[1] && !I_word) ? K_MULH : K_MUL;

  // Restoring division step: remainder lives in acc low half, divisor in mcand low half.
  assign div_t   = {acc_q[XLEN-1:0], quot_q[XLEN-1]};
  assign div_sub = div_t - {1'b0, mcand_q[XLEN-1:0]};
  assign div_ge  = div_t >= {1'b0, mcand_q[XLEN-1:0]};
  assign rem_new = div_ge ? div_sub[XLEN-1:0] : div_t[XLEN-1:0];

  assign cnt_last = word_q ? 7'(W - 1) : 7'(XLEN - 1);

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -quot_q : quot_q;
  assign rem_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

  always_comb begin
    fix_raw = prod_fix[XLEN-1:0];
    case (kind_q)
      K_MUL:  fix_raw = prod_fix[XLEN-1:0];
      K_MULH: fix_raw = prod_fix[2*XLEN-1:XLEN];
      K_DIV:  fix_raw = divz_q ? {XLEN{1'b1}} : quot_fix;
      K_REM:  fix_raw = divz_q ? op1_q : rem_fix;
      default: fix_raw = prod_fix[XLEN-1:0];
    endcase
    fix_res = word_q ? {{W{fix_raw[W-1]}}, fix_raw[W-1:0]} : fix_raw;
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    quot_d   = quot_q;
    op1_d    = op1_q;
    result_d = result_q;
    word_d   = word_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: if (start_ok) begin
        kind_d = kind_sel;
        word_d = I_word;
        neg_d  = I_op[3] ? neg1 : (neg1 ^ neg2);
        divz_d = is_div && (op2_ext == '0);
        op1_d  = op1_ext;
        cnt_d  = '0;
        acc_d  = '0;
        if (is_div) begin
          mcand_d = {{XLEN{1'b0}}, mag2};
          quot_d  = I_word ? (mag1 << W) : mag1;
        end else begin
          mcand_d = {{XLEN{1'b0}}, mag1};
          quot_d  = mag2;
        end
        state_d = (is_div && (op2_ext == '0)) ? FIX : CALC;
      end
      CALC: begin
        cnt_d = cnt_q + 7'd1;
        if (kind_q == K_MUL || kind_q == K_MULH) begin
          if (quot_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          quot_d  = quot_q >> 1;
        end else begin
          acc_d  = {{XLEN{1'b0}}, rem_new};
          quot_d = {quot_q[XLEN-2:0], div_ge};
        end
        if (cnt_q == cnt_last) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: if (I_out_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything and leaves the last result visible.
    if (I_flush) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= IDLE;
      kind_q   <= K_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      quot_q   <= '0;
      op1_q    <= '0;
      result_q <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      quot_q   <= quot_d;
      op1_q    <= op1_d;
      result_q <= result_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      valid_q  <= valid_d;
    end
  end

  assign O_busy   = (state_q != IDLE);
  assign O_valid  = valid_q;
  assign O_result = result_q;
endmodule

// File: tb/tb_ysyx_22040750_mdu.sv
// Self-checking bench for ysyx_22040750_mdu: directed corner cases plus random ops against a reference model.
module tb_ysyx_22040750_mdu;
  localparam logic [3:0] OP_MUL = 4'b0001, OP_MULH = 4'b0010, OP_DIV = 4'b0100, OP_REM = 4'b1000;

  logic        clk, rst_n, start, word, out_ready, flush;
  logic [3:0]  op;
  logic [1:0]  sign;
  logic [63:0] op1, op2;
  logic        busy, valid;
  logic [63:0] result;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] last_res = 64'd0;

  ysyx_22040750_mdu #(.XLEN(64)) dut (
    .I_sys_clk  (clk),
    .I_rst_n    (rst_n),
    .I_start    (start),
    .I_op       (op),
    .I_sign     (sign),
    .I_word     (word),
    .I_op1      (op1),
    .I_op2      (op2),
    .I_out_ready(out_ready),
    .I_flush    (flush),
    .O_busy     (busy),
    .O_valid    (valid),
    .O_result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mdu(input logic [3:0] o, input logic [1:0] sg, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  ae, be, r;
    logic [127:0] pa, pb, p;
    ae = w ? (sg[1] ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    be = w ? (sg[0] ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    pa = sg[1] ? {{64{ae[63]}}, ae} : {64'd0, ae};
    pb = sg[0] ? {{64{be[63]}}, be} : {64'd0, be};
    p  = pa * pb;
    if (o[0] || (o[1] && w))        r = p[63:0];
    else if (o[1])                  r = p[127:64];
    else if (be == 64'd0)           r = o[2] ? 64'hFFFF_FFFF_FFFF_FFFF : ae;
    else if (sg[1] && ae == 64'h8000_0000_0000_0000 && be == 64'hFFFF_FFFF_FFFF_FFFF)
                                    r = o[2] ? ae : 64'd0;
    else if (sg[1])                 r = o[2] ? 64'($signed(ae) / $signed(be)) : 64'($signed(ae) % $signed(be));
    else                            r = o[2] ? ae / be : ae % be;
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Issue one op, wait for O_valid, check result/latency against the scoreboard, hold, then consume.
  task automatic run_op(input string name, input logic [3:0] o, input logic [1:0] sg, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    sb.push_back('{name, exp_res, exp_lat});
    @(negedge clk);
    op = o; sign = sg; word = w; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    n_vec++;
    if (!valid) begin
      n_bad++;
      $display("FAIL %s timeout: O_valid never rose within %0d cycles", e.name, lat);
      flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
      return;
    end
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles, want %0d", e.name, lat, e.lat);
    end
    if (result !== e.res) begin
      n_bad++;
      $display("FAIL %s result: got %h, want %h", e.name, result, e.res);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (valid !== 1'b1 || result !== e.res) begin
        n_bad++;
        $display("FAIL %s hold[%0d]: valid=%b result=%h, want valid=1 result=%h", e.name, i, valid, result, e.res);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s consume: valid=%b busy=%b, want 0 0", e.name, valid, busy);
    end
    last_res = e.res;
    $display("op %-10s a=%h b=%h -> %h lat=%0d", e.name, a, b, result, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 4'd0; sign = 2'd0; word = 1'b0;
    op1 = 64'd0; op2 = 64'd0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%b valid=%b result=%h, want 0 0 0", busy, valid, result);
    end
    $display("reset busy=%b valid=%b result=%h", busy, valid, result);
  endtask

  task automatic test_mul();
    run_op("MUL", OP_MUL, 2'b11, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
    run_op("MULHU", OP_MULH, 2'b00, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("MULHSU", OP_MULH, 2'b10, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
  endtask

  task automatic test_div_overflow();
    run_op("DIV_OVF", OP_DIV, 2'b11, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 66, 0);
    run_op("REM_OVF", OP_REM, 2'b11, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 66, 0);
  endtask

  task automatic test_div_zero();
    run_op("DIVU_Z", OP_DIV, 2'b00, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op("REMW_Z", OP_REM, 2'b11, 1'b1, 64'h1_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2, 0);
  endtask

  task automatic test_word_hold();
    run_op("DIVUW", OP_DIV, 2'b00, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 5);
  endtask

  task automatic test_bad_op();
    logic [3:0] bad [2];
    bad[0] = 4'b0000; bad[1] = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op = bad[i]; sign = 2'b11; word = 1'b0; op1 = 64'd9; op2 = 64'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_op %b: busy=%b, want 0", bad[i], busy);
      end
      $display("bad_op %b busy=%b", bad[i], busy);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    op = OP_DIV; sign = 2'b11; word = 1'b0; op1 = 64'd1000; op2 = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== last_res) begin
      n_bad++;
      $display("FAIL flush: busy=%b valid=%b result=%h, want 0 0 %h", busy, valid, result, last_res);
    end
    $display("flush busy=%b valid=%b result=%h", busy, valid, result);
    run_op("DIV_AFTFL", OP_DIV, 2'b11, 1'b0, 64'd1000, 64'd7, 64'd142, 66, 0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    op = OP_MUL; sign = 2'b00; word = 1'b0; op1 = 64'd12345; op2 = 64'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b valid=%b result=%h, want 0 0 0", busy, valid, result);
    end
    $display("async_reset busy=%b valid=%b result=%h", busy, valid, result);
    @(negedge clk); rst_n = 1'b1;
    run_op("MUL_AFTRST", OP_MUL, 2'b00, 1'b0, 64'd12345, 64'd678, 64'd8369910, 66, 0);
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op = OP_MUL; sign = 2'b11; word = 1'b1; op1 = 64'd6; op2 = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_vec++;
    if (valid !== 1'b1 || result !== 64'd42 || lat !== 34) begin
      n_bad++;
      $display("FAIL b2b first: valid=%b result=%h lat=%0d, want 1 %h 34", valid, result, lat, 64'd42);
    end
    out_ready = 1'b1; start = 1'b1; op = OP_DIV; op1 = 64'd100; op2 = 64'd5;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b ignored_start: busy=%b valid=%b, want 0 0", busy, valid);
    end
    $display("b2b first=%h busy_after=%b", 64'd42, busy);
    last_res = 64'd42;
    run_op("DIVW_B2B", OP_DIV, 2'b11, 1'b1, 64'd100, 64'd5, 64'd20, 34, 0);
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [1:0]  sg;
    logic        w, bz;
    logic [63:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 4'b0001 << $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if (o[3] || o[2]) begin
        sg = {2{1'($urandom_range(0, 1))}};
        b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 60);
      end else begin
        sg = 2'($urandom_range(0, 3));
        b  = {$urandom, $urandom};
      end
      bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      run_op("RANDOM", o, sg, w, a, b, ref_mdu(o, sg, w, a, b),
             ((o[3] || o[2]) && bz) ? 2 : (w ? 34 : 66), 0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_overflow();
    test_div_zero();
    test_word_hold();
    test_bad_op();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
